// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, write-back mux, ALU, Z/N/C flags and an
// optional shift-add multiplier compiled in when DATAPATH_MUL_EN is defined.
module datapath_mc #(
    parameter  int DW   = 16,
    parameter  int NREG = 16,
    parameter  int IMMW = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   RF_W_addr,
    input  logic            RF_W_wr,
    input  logic [1:0]      RF_sel,
    input  logic [IMMW-1:0] RF_W_data,
    input  logic [DW-1:0]   DM_Din,
    input  logic [AW-1:0]   RF_Rp_addr,
    input  logic [AW-1:0]   RF_Rq_addr,
    input  logic            RF_Rp_rd,
    input  logic            RF_Rq_rd,
    input  logic [2:0]      alu_op,
    input  logic            op_start,
    output logic [DW-1:0]   Rp_data,
    output logic            RF_Rp_zero,
    output logic [2:0]      flags,
    output logic            busy,
    output logic            done
);
    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];
    logic [2:0]    flags_q, flags_d;
    logic [DW-1:0] a_data, b_data, alu_res, wb_data;
    logic          alu_c;
    logic [DW:0]   sum, diff;
    logic          mul_wr, mul_hi_nz;
    logic [DW-1:0] mul_lo;
    logic [AW-1:0] mul_dst;

    assign a_data     = RF_Rp_rd ? rf_q[RF_Rp_addr] : '0;
    assign b_data     = RF_Rq_rd ? rf_q[RF_Rq_addr] : '0;
    assign Rp_data    = a_data;
    assign RF_Rp_zero = (a_data == '0);
    assign flags      = flags_q;
    assign sum        = {1'b0, a_data} + {1'b0, b_data};
    assign diff       = {1'b0, a_data} - {1'b0, b_data};

    always_comb begin
        alu_res = a_data;
        alu_c   = 1'b0;
        case (alu_op)
            3'b000: alu_res = a_data;
            3'b001: begin alu_res = sum[DW-1:0];  alu_c = sum[DW];  end
            3'b010: begin alu_res = diff[DW-1:0]; alu_c = diff[DW]; end
            3'b011: alu_res = a_data & b_data;
            3'b100: alu_res = a_data | b_data;
            3'b101: alu_res = a_data ^ b_data;
            3'b110: begin alu_res = {a_data[DW-2:0], 1'b0}; alu_c = a_data[DW-1]; end
            default: alu_res = b_data;
        endcase
    end

    always_comb begin
        case (RF_sel)
            2'b00:   wb_data = alu_res;
            2'b01:   wb_data = DM_Din;
            2'b10:   wb_data = DW'(RF_W_data);
            default: wb_data = a_data;
        endcase
    end

`ifdef DATAPATH_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int         CW     = $clog2(DW + 1);

    logic [1:0]      state_q, state_d;
    logic [2*DW-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   dst_q, dst_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        case (state_q)
            S_IDLE: if (op_start && alu_op == 3'b111) begin
                // Operands latched here so a destination that is also a source is safe.
                state_d  = S_RUN;
                acc_d    = '0;
                mcand_d  = {{DW{1'b0}}, a_data};
                mplier_d = b_data;
                cnt_d    = CW'(DW);
                dst_d    = RF_W_addr;
            end
            S_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mul_wr    = done;
    assign mul_lo    = acc_q[DW-1:0];
    assign mul_hi_nz = (acc_q[2*DW-1:DW] != '0);
    assign mul_dst   = dst_q;
`else
    logic unused_op_start;
    assign unused_op_start = op_start;
    assign busy      = 1'b0;
    assign done      = 1'b0;
    assign mul_wr    = 1'b0;
    assign mul_lo    = '0;
    assign mul_hi_nz = 1'b0;
    assign mul_dst   = '0;
`endif

    // External writes are dropped while the multiplier owns the write port.
    always_comb begin
        rf_d    = rf_q;
        flags_d = flags_q;
        if (mul_wr) begin
            rf_d[mul_dst] = mul_lo;
            flags_d       = {mul_lo == '0, mul_lo[DW-1], mul_hi_nz};
        end else if (RF_W_wr && !busy) begin
            rf_d[RF_W_addr] = wb_data;
            if (RF_sel == 2'b00) flags_d = {alu_res == '0, alu_res[DW-1], alu_c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            flags_q <= '0;
        end else begin
            rf_q    <= rf_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_datapath_mc.sv
// Bench for datapath_mc: directed test-plan steps plus random ALU/write traffic
// against an arithmetic reference model; multiplier steps follow DATAPATH_MUL_EN.
`timescale 1ns/1ps
module tb_datapath_mc;
    localparam int DW = 16, NREG = 16, IMMW = 8;

    logic            clk = 1'b0, rst = 1'b1;
    logic [3:0]      RF_W_addr = '0, RF_Rp_addr = '0, RF_Rq_addr = '0;
    logic            RF_W_wr = 1'b0, RF_Rp_rd = 1'b0, RF_Rq_rd = 1'b0, op_start = 1'b0;
    logic [1:0]      RF_sel = '0;
    logic [IMMW-1:0] RF_W_data = '0;
    logic [DW-1:0]   DM_Din = '0, Rp_data;
    logic [2:0]      alu_op = '0, flags;
    logic            RF_Rp_zero, busy, done;

    datapath_mc #(.DW(DW), .NREG(NREG), .IMMW(IMMW)) dut (
        .clk(clk), .rst(rst), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr), .RF_sel(RF_sel),
        .RF_W_data(RF_W_data), .DM_Din(DM_Din), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
        .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd), .alu_op(alu_op), .op_start(op_start),
        .Rp_data(Rp_data), .RF_Rp_zero(RF_Rp_zero), .flags(flags), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [15:0] m_reg [NREG];
    logic [2:0]  m_flags = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_flags = '0;
    endtask

    // Reference ALU in plain arithmetic: returns {C, result}.
    function automatic logic [16:0] ref_alu(input logic [2:0] op, input int unsigned a, input int unsigned b);
        int unsigned r;
        logic c;
        c = 1'b0;
        case (op)
            3'd0: r = a;
            3'd1: begin r = (a + b) % 65536; c = (a + b) >= 65536; end
            3'd2: begin r = (a + 65536 - b) % 65536; c = a < b; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin r = (a * 2) % 65536; c = a >= 32768; end
            default: r = b;
        endcase
        return {c, r[15:0]};
    endfunction

    task automatic wr(input logic [1:0] sel, input logic [3:0] dst, input logic [3:0] rp,
                      input logic [3:0] rq, input logic rq_en, input logic [2:0] op,
                      input logic [15:0] din, input logic [7:0] imm);
        logic [16:0] r;
        logic [15:0] a, b, v;
        a = m_reg[rp];
        b = rq_en ? m_reg[rq] : 16'h0;
        r = ref_alu(op, a, b);
        case (sel)
            2'd0: v = r[15:0];
            2'd1: v = din;
            2'd2: v = {8'h00, imm};
            default: v = a;
        endcase
        RF_sel = sel; RF_W_addr = dst; RF_Rp_addr = rp; RF_Rq_addr = rq;
        RF_Rp_rd = 1'b1; RF_Rq_rd = rq_en; alu_op = op; DM_Din = din; RF_W_data = imm; RF_W_wr = 1'b1;
        tick();
        RF_W_wr = 1'b0;
        m_reg[dst] = v;
        if (sel == 2'd0) m_flags = {r[15:0] == 16'h0, r[15:0] >= 16'h8000, r[16]};
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr);
        RF_Rp_addr = addr; RF_Rp_rd = 1'b1; #1;
        chk(tag, Rp_data, m_reg[addr]);
        chk({tag, "_zero"}, RF_Rp_zero, m_reg[addr] == 16'h0);
    endtask

    task automatic rd_exp(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        RF_Rp_addr = addr; RF_Rp_rd = 1'b1; #1;
        chk(tag, Rp_data, exp);
    endtask

`ifdef DATAPATH_MUL_EN
    task automatic mul_run(input logic [3:0] rp, input logic [3:0] rq, input logic [3:0] dst,
                           input int ext_at, input int rst_at);
        int unsigned p;
        logic [15:0] lo;
        bit aborted;
        aborted = 1'b0;
        p = m_reg[rp] * m_reg[rq];
        lo = p[15:0];
        RF_Rp_addr = rp; RF_Rq_addr = rq; RF_Rp_rd = 1'b1; RF_Rq_rd = 1'b1;
        alu_op = 3'b111; RF_W_addr = dst; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        for (int n = 1; n <= DW + 1; n++) begin
            if (n == rst_at) begin
                rst = 1'b1; #1;
                chk("mul_rst_busy", busy, 1'b0);
                chk("mul_rst_done", done, 1'b0);
                tick();
                rst = 1'b0;
                model_reset();
                aborted = 1'b1;
                break;
            end
            if (n == ext_at) begin
                RF_W_addr = 4'd10; RF_sel = 2'b01; DM_Din = 16'hBEEF; RF_W_wr = 1'b1;
            end
            if (n == 3) op_start = 1'b1;
            chk($sformatf("mul_busy_c%0d", n), busy, 1'b1);
            chk($sformatf("mul_done_c%0d", n), done, n == DW + 1);
            tick();
            RF_W_wr = 1'b0; op_start = 1'b0;
        end
        if (aborted) begin
            for (int k = 0; k < 20; k++) begin
                chk("abort_no_busy", busy, 1'b0);
                chk("abort_no_done", done, 1'b0);
                tick();
            end
        end else begin
            m_reg[dst] = lo;
            m_flags = {lo == 16'h0, lo >= 16'h8000, p >= 32'h10000};
            chk("mul_end_busy", busy, 1'b0);
            chk("mul_end_done", done, 1'b0);
        end
        rd_chk("mul_dest", dst);
        chk("mul_flags", flags, m_flags);
    endtask
`endif

    initial begin
        logic [3:0] a0;
        model_reset();
        // 1. reset after random writes and activity
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) wr(2'd1, 4'($urandom), 4'd0, 4'd0, 1'b1, 3'd0, 16'($urandom), 8'h0);
        wr(2'd0, 4'd3, 4'd1, 4'd2, 1'b1, 3'd1, 16'h0, 8'h0);
`ifdef DATAPATH_MUL_EN
        RF_Rp_addr = 4'd1; RF_Rq_addr = 4'd2; alu_op = 3'b111; op_start = 1'b1;
        tick(); op_start = 1'b0; tick(); tick();
`endif
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREG; i++) rd_exp($sformatf("rst_r%0d", i), 4'(i), 16'h0);
        chk("rst_flags", flags, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_zero", RF_Rp_zero, 1'b1);
        RF_Rp_rd = 1'b0; RF_Rp_addr = 4'd0; #1;
        chk("rd_off_zero", RF_Rp_zero, 1'b1);

        // 2. immediate, add, sub, move
        wr(2'd2, 4'd1, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0, 8'hFF);
        wr(2'd2, 4'd2, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0, 8'h01);
        wr(2'd0, 4'd3, 4'd1, 4'd2, 1'b1, 3'd1, 16'h0, 8'h0);
        rd_exp("add_r3", 4'd3, 16'h0100);
        chk("add_flags", flags, 3'b000);
        wr(2'd0, 4'd4, 4'd2, 4'd1, 1'b1, 3'd2, 16'h0, 8'h0);
        rd_exp("sub_r4", 4'd4, 16'hFF02);
        chk("sub_flags", flags, 3'b011);
        wr(2'd3, 4'd5, 4'd4, 4'd0, 1'b1, 3'd0, 16'h0, 8'h0);
        rd_exp("mov_r5", 4'd5, 16'hFF02);
        chk("mov_flags", flags, 3'b011);

        // Read-during-write returns the old value
        RF_sel = 2'd1; RF_W_addr = 4'd5; DM_Din = 16'h1234; RF_W_wr = 1'b1;
        RF_Rp_addr = 4'd5; #1;
        chk("rdw_old", Rp_data, 16'hFF02);
        tick(); RF_W_wr = 1'b0; m_reg[5] = 16'h1234;
        rd_chk("rdw_new", 4'd5);

        // 3. DM write and carry-out to zero
        wr(2'd1, 4'd6, 4'd0, 4'd0, 1'b1, 3'd0, 16'hFFFF, 8'h0);
        wr(2'd0, 4'd7, 4'd6, 4'd2, 1'b1, 3'd1, 16'h0, 8'h0);
        rd_exp("add0_r7", 4'd7, 16'h0000);
        chk("add0_zero", RF_Rp_zero, 1'b1);
        chk("add0_flags", flags, 3'b101);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            a0 = 4'($urandom);
            wr(2'($urandom), a0, 4'($urandom), 4'($urandom), 1'($urandom),
               3'($urandom), 16'($urandom), 8'($urandom));
            rd_chk($sformatf("rnd_%0d", i), a0);
            chk($sformatf("rnd_flags_%0d", i), flags, m_flags);
        end

        // 4. multiply, dest equals a source, dropped external write
        wr(2'd1, 4'd8, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0123, 8'h0);
        wr(2'd1, 4'd9, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0010, 8'h0);
        wr(2'd1, 4'd10, 4'd0, 4'd0, 1'b1, 3'd0, 16'h00AA, 8'h0);
`ifdef DATAPATH_MUL_EN
        mul_run(4'd8, 4'd9, 4'd8, 5, 0);
        rd_exp("mul_r8", 4'd8, 16'h1230);
        chk("mul_r8_flags", flags, 3'b000);
        rd_exp("drop_r10", 4'd10, 16'h00AA);
`else
        // 6. no multiplier: op_start is ignored
        RF_Rp_addr = 4'd8; RF_Rq_addr = 4'd9; RF_Rq_rd = 1'b1; alu_op = 3'b111; op_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("nomul_busy", busy, 1'b0);
            chk("nomul_done", done, 1'b0);
        end
        op_start = 1'b0;
        wr(2'd1, 4'd10, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0055, 8'h0);
        rd_exp("nomul_wr_r10", 4'd10, 16'h0055);
`endif
        wr(2'd0, 4'd13, 4'd6, 4'd9, 1'b1, 3'b111, 16'h0, 8'h0);
        rd_exp("passb_r13", 4'd13, 16'h0010);
        chk("passb_flags", flags, 3'b000);

`ifdef DATAPATH_MUL_EN
        // 5. overflowing multiply, then reset mid-run
        wr(2'd1, 4'd11, 4'd0, 4'd0, 1'b1, 3'd0, 16'h8000, 8'h0);
        wr(2'd2, 4'd12, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0, 8'h02);
        mul_run(4'd11, 4'd12, 4'd14, 0, 0);
        rd_exp("mulc_r14", 4'd14, 16'h0000);
        chk("mulc_flags", flags, 3'b101);
        wr(2'd1, 4'd15, 4'd0, 4'd0, 1'b1, 3'd0, 16'h5A5A, 8'h0);
        mul_run(4'd11, 4'd12, 4'd15, 0, 6);
        // back-to-back launch straight after a completed run
        wr(2'd1, 4'd1, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0003, 8'h0);
        wr(2'd1, 4'd2, 4'd0, 4'd0, 1'b1, 3'd0, 16'h0005, 8'h0);
        mul_run(4'd1, 4'd2, 4'd3, 0, 0);
        mul_run(4'd3, 4'd2, 4'd4, 0, 0);
        rd_exp("b2b_r4", 4'd4, 16'd75);
`endif
        for (int i = 0; i < NREG; i++) rd_chk($sformatf("final_r%0d", i), 4'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
